// File: rtl/rf_pkg.sv
// ============================================================================
// Package : rf_pkg
// Shared types and register-index constants for the banked interrupt-level
// register file.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NUM_REGS_DEF   = 32;
    localparam int unsigned NUM_LEVELS_DEF = 4;

    typedef logic [DATA_WIDTH_DEF-1:0]          DataT;
    typedef logic [$clog2(NUM_REGS_DEF)-1:0]    AddrT;
    typedef logic [$clog2(NUM_LEVELS_DEF)-1:0]  LevelT;

    localparam int unsigned Zero = 0;
    localparam int unsigned Ra   = 1;
    localparam int unsigned Sp   = 2;

    localparam DataT RaMagic = '1;

endpackage

`default_nettype wire

// File: rtl/rf_bank.sv
// ============================================================================
// Module : rf_bank
// One NumRegs x DataWidth register bank with async clear, one data write
// port, a dedicated ra-link set, and three combinational read ports.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_bank
    import rf_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumRegs   = 32,
    parameter int RegsWidth = $clog2(NumRegs)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [RegsWidth-1:0] write_addr,
    input  logic [DataWidth-1:0] write_data,
    input  logic                 ra_set,
    input  logic [RegsWidth-1:0] read_addr1,
    input  logic [RegsWidth-1:0] read_addr2,
    output logic [DataWidth-1:0] read_data1,
    output logic [DataWidth-1:0] read_data2,
    output logic [DataWidth-1:0] read_ra
);

    localparam logic [RegsWidth-1:0] RA_IDX = RegsWidth'(Ra);

    logic [NumRegs-1:0][DataWidth-1:0] regs_q;
    logic [NumRegs-1:0][DataWidth-1:0] regs_d;

    // The ra-link set and the data write never target the same bank entry
    // from the top level, so their relative order here is immaterial.
    always_comb begin
        regs_d = regs_q;
        if (ra_set) begin
            regs_d[RA_IDX] = {DataWidth{1'b1}};
        end
        if (write_en) begin
            regs_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign read_data1 = regs_q[read_addr1];
    assign read_data2 = regs_q[read_addr2];
    assign read_ra    = regs_q[RA_IDX];

endmodule

`default_nettype wire

// File: rtl/rf_stack_banked.sv
// ============================================================================
// Module : rf_stack_banked
// Banked RISC-V integer register file, one bank per interrupt level, with a
// shared sp in bank 0, write-through reads and an ra-link port.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_stack_banked
    import rf_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int NumRegs     = 32,
    parameter int NumLevels   = 4,
    parameter int LevelsWidth = (NumLevels > 1) ? $clog2(NumLevels) : 1,
    parameter int RegsWidth   = $clog2(NumRegs)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   writeEn,
    input  logic                   writeRaEn,
    input  logic [LevelsWidth-1:0] level,
    input  logic [RegsWidth-1:0]   writeAddr,
    input  logic [DataWidth-1:0]   writeData,
    input  logic [RegsWidth-1:0]   readAddr1,
    input  logic [RegsWidth-1:0]   readAddr2,
    output logic [DataWidth-1:0]   readData1,
    output logic [DataWidth-1:0]   readData2,
    output logic [DataWidth-1:0]   readRa
);

    localparam logic [RegsWidth-1:0] ZERO_IDX = RegsWidth'(Zero);
    localparam logic [RegsWidth-1:0] SP_IDX   = RegsWidth'(Sp);

    logic                   level_ok;
    logic                   write_valid;
    logic [LevelsWidth-1:0] write_bank;
    logic [LevelsWidth-1:0] link_bank;
    logic                   link_valid;

    logic [DataWidth-1:0] bank_rd1 [NumLevels];
    logic [DataWidth-1:0] bank_rd2 [NumLevels];
    logic [DataWidth-1:0] bank_ra  [NumLevels];

    logic [DataWidth-1:0] sel_rd1;
    logic [DataWidth-1:0] sel_rd2;
    logic [DataWidth-1:0] sel_sp1;
    logic [DataWidth-1:0] sel_sp2;
    logic [DataWidth-1:0] sel_ra;

    assign level_ok    = (32'(level) < NumLevels);
    assign write_bank  = (writeAddr == SP_IDX) ? '0 : level;
    assign write_valid = writeEn && (writeAddr != ZERO_IDX) && level_ok;
    assign link_bank   = level - LevelsWidth'(1);
    assign link_valid  = writeRaEn && (level != '0) && level_ok;

    generate
        for (genvar g = 0; g < NumLevels; g++) begin : g_bank
            rf_bank #(
                .DataWidth (DataWidth),
                .NumRegs   (NumRegs),
                .RegsWidth (RegsWidth)
            ) u_bank (
                .clk        (clk),
                .reset      (reset),
                .write_en   (write_valid && (write_bank == LevelsWidth'(g))),
                .write_addr (writeAddr),
                .write_data (writeData),
                .ra_set     (link_valid && (link_bank == LevelsWidth'(g))),
                .read_addr1 (readAddr1),
                .read_addr2 (readAddr2),
                .read_data1 (bank_rd1[g]),
                .read_data2 (bank_rd2[g]),
                .read_ra    (bank_ra[g])
            );
        end
    endgenerate

    // Out-of-range levels match no bank, so their selections fall back to 0.
    always_comb begin
        sel_rd1 = '0;
        sel_rd2 = '0;
        sel_ra  = '0;
        for (int g = 0; g < NumLevels; g++) begin
            if (level == LevelsWidth'(g)) begin
                sel_rd1 = bank_rd1[g];
                sel_rd2 = bank_rd2[g];
                sel_ra  = bank_ra[g];
            end
        end
        sel_sp1 = bank_rd1[0];
        sel_sp2 = bank_rd2[0];
    end

    always_comb begin
        readData1 = '0;
        if (readAddr1 == ZERO_IDX) begin
            readData1 = '0;
        end else if (writeEn && (writeAddr == readAddr1)) begin
            readData1 = writeData;
        end else if (readAddr1 == SP_IDX) begin
            readData1 = sel_sp1;
        end else begin
            readData1 = sel_rd1;
        end
    end

    always_comb begin
        readData2 = '0;
        if (readAddr2 == ZERO_IDX) begin
            readData2 = '0;
        end else if (writeEn && (writeAddr == readAddr2)) begin
            readData2 = writeData;
        end else if (readAddr2 == SP_IDX) begin
            readData2 = sel_sp2;
        end else begin
            readData2 = sel_rd2;
        end
    end

    assign readRa = sel_ra;

endmodule

`default_nettype wire

// File: tb/tb_rf_stack_banked.sv
// ============================================================================
// Module : tb_rf_stack_banked
// Directed self-checking bench for rf_stack_banked.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_stack_banked;

    logic        clk;
    logic        reset;
    logic        writeEn;
    logic        writeRaEn;
    logic [1:0]  level;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] readRa;

    int n_cmp;
    int n_err;

    rf_stack_banked dut (
        .clk       (clk),
        .reset     (reset),
        .writeEn   (writeEn),
        .writeRaEn (writeRaEn),
        .level     (level),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .readData1 (readData1),
        .readData2 (readData2),
        .readRa    (readRa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        writeEn   = 1'b0;
        writeRaEn = 1'b0;
        level     = 2'd0;
        writeAddr = 5'd0;
        writeData = 32'h0;
        readAddr1 = 5'd1;
        readAddr2 = 5'd2;
        #2 reset  = 1'b0;
        #1;
        check("reset_rd1", readData1, 32'h0);
        check("reset_rd2", readData2, 32'h0);
        check("reset_ra",  readRa,    32'h0);
        #3 reset = 1'b1;

        // Step 1: sp write at level 1 lands in bank 0
        level = 2'd1; writeEn = 1'b1; writeAddr = 5'd2; writeData = 32'h12345678;
        tick();
        writeEn = 1'b0; readAddr1 = 5'd2;
        #1 check("sp_lvl1", readData1, 32'h12345678);
        level = 2'd0;
        #1 check("sp_lvl0", readData1, 32'h12345678);

        // Step 2: private register at level 1
        level = 2'd1; writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h00001111;
        tick();
        writeEn = 1'b0; readAddr1 = 5'd3; readAddr2 = 5'd2;
        #1 check("x3_lvl1", readData1, 32'h00001111);
        level = 2'd0;
        #1 check("x3_lvl0", readData1, 32'h0);
        check("sp_kept", readData2, 32'h12345678);

        // Step 3: write-through before any edge
        level = 2'd2; writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h11110000;
        readAddr1 = 5'd3; readAddr2 = 5'd2;
        #1 check("wt_rd1", readData1, 32'h11110000);
        check("wt_rd2_sp", readData2, 32'h12345678);
        writeEn = 1'b0;
        #1 check("wt_off", readData1, 32'h0);

        // Step 4: ra link alongside x1 write at level 2
        level = 2'd2; writeEn = 1'b1; writeRaEn = 1'b1; writeAddr = 5'd1;
        writeData = 32'hffffeeee; readAddr1 = 5'd1;
        tick();
        writeEn = 1'b0; writeRaEn = 1'b0;
        #1 check("x1_lvl2", readData1, 32'hffffeeee);
        check("ra_lvl2", readRa, 32'hffffeeee);
        level = 2'd1;
        #1 check("ra_lvl1_link", readRa, 32'hffffffff);
        check("x1_lvl1_link", readData1, 32'hffffffff);
        level = 2'd0;
        #1 check("ra_lvl0_untouched", readRa, 32'h0);

        // Step 5: x0 stays zero, and ra link at level 0 is inert
        level = 2'd2; writeEn = 1'b1; writeAddr = 5'd0; writeData = 32'hdeadbeef;
        readAddr1 = 5'd0;
        #1 check("x0_wt", readData1, 32'h0);
        tick();
        writeEn = 1'b0;
        #1 check("x0_after", readData1, 32'h0);
        level = 2'd0; writeEn = 1'b1; writeRaEn = 1'b1; writeAddr = 5'd5;
        writeData = 32'ha5a5a5a5;
        tick();
        writeEn = 1'b0; writeRaEn = 1'b0; readAddr1 = 5'd5;
        #1 check("x5_lvl0", readData1, 32'ha5a5a5a5);
        check("ra_lvl0_nolink", readRa, 32'h0);
        level = 2'd3;
        #1 check("ra_lvl3", readRa, 32'h0);
        check("x5_lvl3", readData1, 32'h0);
        level = 2'd1;
        #1 check("ra_lvl1_kept", readRa, 32'hffffffff);

        // Step 6: async reset between edges
        readAddr1 = 5'd1; readAddr2 = 5'd2;
        @(negedge clk);
        reset = 1'b0;
        #1 check("areset_rd1", readData1, 32'h0);
        check("areset_rd2", readData2, 32'h0);
        check("areset_ra",  readRa,    32'h0);
        #2 reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
